// File: rtl/vend_payout.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// vend_payout
//
// Payout controller that sits behind the vend FSM. A request (y = release one
// can, ch = number of 5-unit change coins) is paid out one item at a time:
// first the can (if requested), then each coin with a hopper settle gap in
// between. Every item must be confirmed by its drop sensor within TIMEOUT
// motor cycles, otherwise the block parks in a sticky FAULT state until
// fault_clr.
//
// Parameters
//   TIMEOUT : max motor-on cycles per item without a confirmed drop
//   GAP     : motor-off settle cycles between consecutive coins
//   CNT_W   : counter width, 2**CNT_W must exceed max(TIMEOUT, GAP)
//
// Ports
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   y, ch        : request inputs, ch[0] is the MSB of the coin count
//   can_drop     : can-chute sensor, asynchronous
//   coin_drop    : coin-chute sensor, asynchronous
//   fault_clr    : leave FAULT (ignored in every other state)
//   can_motor    : can-release motor drive (registered)
//   coin_motor   : hopper motor drive (registered)
//   busy         : high in every state except IDLE
//   done         : one-cycle pulse when a request completes
//   overrun      : one-cycle pulse when a request arrives while busy
//   fault        : high while in FAULT
//   coins_left   : coins still owed on the current request
// -----------------------------------------------------------------------------
module vend_payout #(
  parameter int TIMEOUT = 1000,
  parameter int GAP     = 4,
  parameter int CNT_W   = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       y,
  input  logic [0:1] ch,
  input  logic       can_drop,
  input  logic       coin_drop,
  input  logic       fault_clr,
  output logic       can_motor,
  output logic       coin_motor,
  output logic       busy,
  output logic       done,
  output logic       overrun,
  output logic       fault,
  output logic [1:0] coins_left
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAN,
    S_COIN,
    S_GAP,
    S_DONE,
    S_FAULT
  } state_t;

  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP - 1);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic [1:0]       coins_nx;
  logic             req;
  logic             to_hit;

  // Sensor synchronizers: _p0/_p1 are the 2-FF synchronizer, _p2 holds the
  // previous synchronized value for rising-edge detection.
  logic can_sync_p0, can_sync_p1, can_sync_p2;
  logic coin_sync_p0, coin_sync_p1, coin_sync_p2;
  logic can_evt;
  logic coin_evt;

  // ---- stage 0..2: sensor synchronization and edge detect ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      can_sync_p0  <= 1'b0;
      can_sync_p1  <= 1'b0;
      can_sync_p2  <= 1'b0;
      coin_sync_p0 <= 1'b0;
      coin_sync_p1 <= 1'b0;
      coin_sync_p2 <= 1'b0;
    end else begin
      can_sync_p0  <= can_drop;
      can_sync_p1  <= can_sync_p0;
      can_sync_p2  <= can_sync_p1;
      coin_sync_p0 <= coin_drop;
      coin_sync_p1 <= coin_sync_p0;
      coin_sync_p2 <= coin_sync_p1;
    end
  end

  // A sensor held high yields a single event; the FSM only looks at the
  // event that matches the motor it is currently running.
  assign can_evt  = can_sync_p1 & ~can_sync_p2;
  assign coin_evt = coin_sync_p1 & ~coin_sync_p2;

  assign req    = y | (ch != 2'b00);
  assign to_hit = (cnt == TO_LAST);

  // ---- FSM next state ----
  always_comb begin
    state_nx = state;
    coins_nx = coins_left;
    unique case (state)
      S_IDLE: begin
        if (req) begin
          coins_nx = ch;
          state_nx = y ? S_CAN : S_COIN;
        end
      end
      S_CAN: begin
        // A drop on the timeout edge still counts as a good payout.
        if (can_evt) begin
          state_nx = (coins_left != 2'd0) ? S_COIN : S_DONE;
        end else if (to_hit) begin
          state_nx = S_FAULT;
        end
      end
      S_COIN: begin
        if (coin_evt) begin
          coins_nx = coins_left - 2'd1;
          state_nx = (coins_left != 2'd1) ? S_GAP : S_DONE;
        end else if (to_hit) begin
          state_nx = S_FAULT;
        end
      end
      S_GAP: begin
        if (cnt == GAP_LAST) begin
          state_nx = S_COIN;
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      S_FAULT: begin
        // coins_left is left untouched here so the stuck item can be read out.
        if (fault_clr) begin
          coins_nx = 2'd0;
          state_nx = S_IDLE;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // The counter restarts on every state change, so each timed state begins
  // at zero and leaves at its limit before the counter could wrap.
  always_comb begin
    cnt_nx = '0;
    if (state_nx == state) begin
      if ((state == S_CAN) || (state == S_COIN) || (state == S_GAP)) begin
        cnt_nx = cnt + CNT_W'(1);
      end
    end
  end

  // ---- FSM state and registered outputs ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      coins_left <= 2'd0;
      can_motor  <= 1'b0;
      coin_motor <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overrun    <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      coins_left <= coins_nx;
      can_motor  <= (state_nx == S_CAN);
      coin_motor <= (state_nx == S_COIN);
      busy       <= (state_nx != S_IDLE);
      done       <= (state_nx == S_DONE);
      fault      <= (state_nx == S_FAULT);
      // A request that lands while busy is dropped; only this flag reports it.
      overrun    <= (state != S_IDLE) && req;
    end
  end

endmodule
